// File: rtl/inter_cache_req_arbiter.sv
// inter_cache_req_arbiter
// Shares one inter_cache_pipe_hit_pipe between IBC (port 0) and inter-pred
// (port 1). Requests are granted round-robin onto the cache upstream interface.
// The winner of each issued request is kept in an in-order tag FIFO so that
// returned blocks (delivered by the cache in issue order) reach their owner.
// Optional build macro CACHE_ARB_PERF_EN adds saturating grant/stall counters.
//
// state    | meaning
// ST_IDLE  | may grant; req_ready asserts for the winner this cycle
// ST_ISSUE | cache_valid high for the latched request
// ST_HOLD  | dead cycle so cache_idle reflects the new request
module inter_cache_req_arbiter #(
    parameter int COORD_WDTH    = 14,
    parameter int DIM_WDTH      = 6,
    parameter int REF_ADDR_WDTH = 4,
    parameter int TAG_DEPTH     = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [1:0]                 req_valid,
    output logic [1:0]                 req_ready,
    input  logic [2*REF_ADDR_WDTH-1:0] req_ref_idx,
    input  logic [2*COORD_WDTH-1:0]    req_start_x,
    input  logic [2*COORD_WDTH-1:0]    req_start_y,
    input  logic [2*DIM_WDTH-1:0]      req_width,
    input  logic [2*DIM_WDTH-1:0]      req_height,
    output logic [1:0]                 resp_valid,
    input  logic [1:0]                 resp_filer_idle,
    output logic                       cache_valid,
    input  logic                       cache_idle,
    output logic [REF_ADDR_WDTH-1:0]   cache_ref_idx,
    output logic [COORD_WDTH-1:0]      cache_start_x,
    output logic [COORD_WDTH-1:0]      cache_start_y,
    output logic [DIM_WDTH-1:0]        cache_width,
    output logic [DIM_WDTH-1:0]        cache_height,
    input  logic                       cache_blk_valid,
    output logic                       cache_filer_idle,
`ifdef CACHE_ARB_PERF_EN
    output logic [31:0]                perf_grant0,
    output logic [31:0]                perf_grant1,
    output logic [31:0]                perf_stall,
`endif
    output logic                       err_orphan
);

    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             rr_ptr;
    logic             winner;
    logic             grant;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             tag_mem [TAG_DEPTH];

    assign fifo_full  = (count == CNT_W'(TAG_DEPTH));
    assign fifo_empty = (count == '0);
    assign head       = tag_mem[rd_ptr];

    // first valid requester at or after rr_ptr
    assign winner = rr_ptr ? (req_valid[1] ? 1'b1 : 1'b0)
                           : (req_valid[0] ? 1'b0 : 1'b1);

    // grant is blocked while the cache is busy or every tag slot is in use
    assign grant = !reset && (state == ST_IDLE) && cache_idle && !fifo_full && (|req_valid);
    assign pop   = !reset && cache_blk_valid && !fifo_empty;

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (grant) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_HOLD;
            ST_HOLD:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: one-cycle issue strobe and combinational accept
    always_comb begin
        cache_valid = (state == ST_ISSUE);
        req_ready   = 2'b00;
        if (grant) req_ready = winner ? 2'b10 : 2'b01;
    end

    // return path routed by the oldest outstanding tag
    always_comb begin
        resp_valid       = 2'b00;
        cache_filer_idle = 1'b1;
        if (pop)         resp_valid = head ? 2'b10 : 2'b01;
        if (!fifo_empty) cache_filer_idle = resp_filer_idle[head];
    end

    // latch winner fields and advance the round-robin pointer on grant
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr        <= 1'b0;
            cache_ref_idx <= '0;
            cache_start_x <= '0;
            cache_start_y <= '0;
            cache_width   <= '0;
            cache_height  <= '0;
        end else if (grant) begin
            rr_ptr        <= ~winner;
            cache_ref_idx <= winner ? req_ref_idx[2*REF_ADDR_WDTH-1:REF_ADDR_WDTH] : req_ref_idx[REF_ADDR_WDTH-1:0];
            cache_start_x <= winner ? req_start_x[2*COORD_WDTH-1:COORD_WDTH] : req_start_x[COORD_WDTH-1:0];
            cache_start_y <= winner ? req_start_y[2*COORD_WDTH-1:COORD_WDTH] : req_start_y[COORD_WDTH-1:0];
            cache_width   <= winner ? req_width[2*DIM_WDTH-1:DIM_WDTH] : req_width[DIM_WDTH-1:0];
            cache_height  <= winner ? req_height[2*DIM_WDTH-1:DIM_WDTH] : req_height[DIM_WDTH-1:0];
        end
    end

    // tag FIFO; reset drops any outstanding tags
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (grant) begin
                tag_mem[wr_ptr] <= winner;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(grant) - CNT_W'(pop);
        end
    end

    // sticky flag for a block returned with nothing outstanding
    always_ff @(posedge clk) begin
        if (reset)                              err_orphan <= 1'b0;
        else if (cache_blk_valid && fifo_empty) err_orphan <= 1'b1;
    end

`ifdef CACHE_ARB_PERF_EN
    // saturating grant and stall counters
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_grant0 <= '0;
            perf_grant1 <= '0;
            perf_stall  <= '0;
        end else begin
            if (grant && !winner && (perf_grant0 != '1)) perf_grant0 <= perf_grant0 + 32'd1;
            if (grant && winner && (perf_grant1 != '1))  perf_grant1 <= perf_grant1 + 32'd1;
            if ((state == ST_IDLE) && (|req_valid) && !grant && (perf_stall != '1))
                perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule
